// File: rtl/morse_pkg.sv
// morse_pkg: symbol codes, FSM state encoding and threshold
// multipliers shared by the Morse key front-end.
package morse_pkg;

  localparam logic [2:0] SYM_WAIT  = 3'h0;
  localparam logic [2:0] SYM_DIT   = 3'h1;
  localparam logic [2:0] SYM_DAH   = 3'h2;
  localparam logic [2:0] SYM_GAP   = 3'h3;
  localparam logic [2:0] SYM_SPACE = 3'h4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } key_state_e;

  localparam int unsigned GAP_MULT   = 2;
  localparam int unsigned SPACE_MULT = 5;

endpackage

// File: rtl/morse_sym_fifo.sv
// morse_sym_fifo: DEPTH x 3-bit symbol FIFO (DEPTH power of 2, >= 2).
// Ports: clk, rst_n, push/push_data, pop, head, full, empty.
module morse_sym_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [2:0] push_data,
  input  logic       pop,
  output logic [2:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0] mem_q [DEPTH];
  logic [2:0] mem_d [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic do_push, do_pop;

  // Extra pointer bit separates full from empty.
  assign empty   = wr_q == rd_q;
  assign full    = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign do_pop  = pop && !empty;
  // A pop on a full FIFO frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (do_pop) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: 3'h0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/morse_key_ctrl.sv
// morse_key_ctrl: key sync, tick timebase, mark/space timer, symbol
// classifier and FIFO. Ports: clk, rst_n, key_in, sym_data/sym_valid/
// sym_ready, dit_len, overflow. MORSE_ADAPTIVE_EN enables adaptive dit_len.
module morse_key_ctrl
  import morse_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 1000,
  parameter int DIT_INIT = 50,
  parameter int DIT_MIN  = 2,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_in,
  output logic [2:0]       sym_data,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [CNT_W-1:0] dit_len,
  output logic             overflow
);

  localparam int XW = CNT_W + 3;
  localparam int TW = $clog2(TICK_DIV);
  // Reset estimate never starts below the clamp floor.
  localparam int DIT_RST = (DIT_INIT > DIT_MIN) ? DIT_INIT : DIT_MIN;

  logic sync1_q, sync2_q, key_q, key_prev_q;
  logic rise, fall, key_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      key_q      <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      sync1_q    <= key_in;
      sync2_q    <= sync1_q;
      key_q      <= sync2_q;
      key_prev_q <= key_q;
    end
  end

  assign rise     = key_q && !key_prev_q;
  assign fall     = !key_q && key_prev_q;
  assign key_edge = key_q ^ key_prev_q;

  logic [TW-1:0] pre_q, pre_d;
  logic tick;

  assign tick  = pre_q == TW'(TICK_DIV - 1);
  assign pre_d = tick ? '0 : pre_q + TW'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (key_edge) cnt_d = '0;
    else if (tick && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  logic [XW-1:0] len_x, dit_x, thr_gap, thr_space;

  assign len_x     = XW'(cnt_q);
  assign dit_x     = XW'(dit_len);
  assign thr_gap   = dit_x * XW'(GAP_MULT);
  assign thr_space = dit_x * XW'(SPACE_MULT);

  key_state_e state_q, state_d;
  logic gap_sent_q, gap_sent_d;
  logic push;
  logic [2:0] push_sym;

  always_comb begin
    state_d    = state_q;
    gap_sent_d = gap_sent_q;
    push       = 1'b0;
    push_sym   = SYM_WAIT;
    unique case (state_q)
      ST_IDLE: if (rise) state_d = ST_MARK;
      ST_MARK: begin
        if (fall) begin
          state_d    = ST_SPACE;
          gap_sent_d = 1'b0;
          if (cnt_q != '0) begin
            push     = 1'b1;
            push_sym = (len_x < thr_gap) ? SYM_DIT : SYM_DAH;
          end
        end
      end
      ST_SPACE: begin
        if (len_x >= thr_space) begin
          push     = 1'b1;
          push_sym = SYM_SPACE;
          state_d  = ST_IDLE;
        end else if (!gap_sent_q && len_x >= thr_gap) begin
          push       = 1'b1;
          push_sym   = SYM_GAP;
          gap_sent_d = 1'b1;
        end
        // Threshold push above still lands when a rise coincides.
        if (rise) state_d = ST_MARK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [2:0] fifo_head;
  logic fifo_full, fifo_empty;
  logic overflow_q, overflow_d;

  morse_sym_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_sym),
    .pop      (sym_ready),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign overflow_d = push && fifo_full && !sym_ready;
  assign sym_valid  = !fifo_empty;
  assign sym_data   = fifo_empty ? SYM_WAIT : fifo_head;
  assign overflow   = overflow_q;

`ifdef MORSE_ADAPTIVE_EN
  logic [CNT_W-1:0] dit_q, dit_d;
  logic [XW-1:0] avg;

  assign avg = (dit_x * XW'(3) + len_x) >> 2;

  always_comb begin
    dit_d = dit_q;
    if (push && push_sym == SYM_DIT)
      dit_d = (avg < XW'(DIT_MIN)) ? CNT_W'(DIT_MIN) : CNT_W'(avg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dit_q <= CNT_W'(DIT_RST);
    else        dit_q <= dit_d;
  end

  assign dit_len = dit_q;
`else
  assign dit_len = CNT_W'(DIT_RST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      gap_sent_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      gap_sent_q <= gap_sent_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_morse_key_ctrl.sv
// tb_morse_key_ctrl: table vectors, corner sequences and random
// mark/space traffic checked against a tick-level symbol model.
module tb_morse_key_ctrl;
  import morse_pkg::*;

  localparam int CNT_W    = 16;
  localparam int TICK_DIV = 4;
  localparam int DIT_INIT = 8;
  localparam int DIT_MIN  = 2;
  localparam int DEPTH    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b0;
  logic sym_ready = 1'b0;
  logic [2:0] sym_data;
  logic sym_valid;
  logic [CNT_W-1:0] dit_len;
  logic overflow;

  int n_chk = 0;
  int n_fail = 0;
  int ovf_cnt = 0;
  int cyc = 0;
  int model_dit = DIT_INIT;
  logic [2:0] rxq[$];
  logic [2:0] expq[$];
  logic hold_prev = 1'b0;
  logic [2:0] data_prev = 3'h0;

  typedef struct {
    int mk;
    int sk;
    int n;
    logic [2:0] e0;
    logic [2:0] e1;
    logic [2:0] e2;
  } vec_t;
  vec_t tbl[7];

  morse_key_ctrl #(
    .CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .DIT_INIT(DIT_INIT),
    .DIT_MIN(DIT_MIN), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .dit_len(dit_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        check("hold_valid", sym_valid, 1);
        check("hold_data", sym_data, data_prev);
      end
      if (sym_valid && sym_ready) rxq.push_back(sym_data);
      if (overflow) ovf_cnt++;
      hold_prev = sym_valid && !sym_ready;
      data_prev = sym_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One tick per TICK_DIV cycles: holding 4k+1 cycles spans exactly k ticks.
  task automatic hold(input logic lvl, input int ticks);
    key_in = lvl;
    cycles(TICK_DIV * ticks + 1);
  endtask

  task automatic model_mark(input int k);
    if (k == 0) return;
    if (k < 2 * model_dit) begin
      expq.push_back(SYM_DIT);
`ifdef MORSE_ADAPTIVE_EN
      model_dit = (3 * model_dit + k) / 4;
      if (model_dit < DIT_MIN) model_dit = DIT_MIN;
`endif
    end else begin
      expq.push_back(SYM_DAH);
    end
  endtask

  task automatic model_space(input int k);
    if (k >= 2 * model_dit) expq.push_back(SYM_GAP);
    if (k >= 5 * model_dit) expq.push_back(SYM_SPACE);
  endtask

  task automatic compare_rx(input string name);
    cycles(12);
    check({name, "_count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check({name, "_sym"}, (i < rxq.size()) ? rxq[i] : 3'h7, expq[i]);
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    int exp_ovf;
    int mk;
    int sk;

    tbl[0] = '{8, 20, 2, SYM_DIT, SYM_GAP, SYM_WAIT};
    tbl[1] = '{24, 45, 3, SYM_DAH, SYM_GAP, SYM_SPACE};
    tbl[2] = '{15, 15, 1, SYM_DIT, SYM_WAIT, SYM_WAIT};
    tbl[3] = '{16, 16, 2, SYM_DAH, SYM_GAP, SYM_WAIT};
    tbl[4] = '{1, 39, 2, SYM_DIT, SYM_GAP, SYM_WAIT};
    tbl[5] = '{0, 3, 0, SYM_WAIT, SYM_WAIT, SYM_WAIT};
    tbl[6] = '{30, 40, 3, SYM_DAH, SYM_GAP, SYM_SPACE};

    cycles(3);
    check("rst_valid", sym_valid, 0);
    check("rst_data", sym_data, SYM_WAIT);
    check("rst_ovf", overflow, 0);
    check("rst_dit", dit_len, DIT_INIT);
    rst_n = 1'b1;
    hold(1'b0, 3);
    check("idle_valid", sym_valid, 0);

`ifndef MORSE_ADAPTIVE_EN
    sym_ready = 1'b1;
    foreach (tbl[i]) begin
      hold(1'b1, tbl[i].mk);
      hold(1'b0, tbl[i].sk);
      if (tbl[i].n > 0) expq.push_back(tbl[i].e0);
      if (tbl[i].n > 1) expq.push_back(tbl[i].e1);
      if (tbl[i].n > 2) expq.push_back(tbl[i].e2);
      check("tbl_dit", dit_len, DIT_INIT);
    end
    compare_rx("table");
`endif

    sym_ready = 1'b0;
    hold(1'b1, 8);
    key_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_before", sym_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_after", sym_valid, 1);
    check("lat_data", sym_data, SYM_DIT);
    @(posedge clk);
    #1;
    sym_ready = 1'b1;
    hold(1'b0, 45);
    model_mark(8);
    model_space(45);
    compare_rx("lat");

    sym_ready = 1'b0;
    ovf_cnt = 0;
    exp_ovf = 0;
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 8);
      hold(1'b0, 3);
      if (i < DEPTH) expq.push_back(SYM_DIT);
      else exp_ovf++;
    end
    cycles(4);
    check("ovf_pulses", ovf_cnt, exp_ovf);
    check("ovf_valid", sym_valid, 1);
    sym_ready = 1'b1;
    hold(1'b0, 45);
    model_space(45);
    compare_rx("ovf");
    check("ovf_after", ovf_cnt, exp_ovf);

    // Start the 2-cycle pulse where no tick falls inside it.
    for (int i = 0; i < 8; i++)
      if (cyc % TICK_DIV != 0) cycles(1);
    ovf_cnt = 0;
    key_in = 1'b1;
    cycles(2);
    hold(1'b0, 5);
    check("glitch_valid", sym_valid, 0);
    check("glitch_none", rxq.size(), 0);
    hold(1'b0, 45);
    model_space(50);
    compare_rx("glitch");
    check("glitch_ovf", ovf_cnt, 0);

    ovf_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      mk = $urandom_range(0, 26);
      sk = (i == 9) ? 45 : $urandom_range(1, 48);
      hold(1'b1, mk);
      hold(1'b0, sk);
      model_mark(mk);
      model_space(sk);
      check("rand_dit", dit_len, model_dit);
    end
    compare_rx("rand");
    check("rand_ovf", ovf_cnt, 0);

    hold(1'b1, 6);
    rst_n = 1'b0;
    key_in = 1'b0;
    cycles(3);
    check("mid_rst_valid", sym_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_data", sym_data, SYM_WAIT);
    rst_n = 1'b1;
    model_dit = DIT_INIT;
    hold(1'b0, 10);
    check("post_rst_valid", sym_valid, 0);
    check("post_rst_none", rxq.size(), 0);
    check("post_rst_dit", dit_len, DIT_INIT);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
